rpn_stack_ctrl: RTL

//  Operand-stack controller that sits directly upstream of the 8-bit ALU (ula8bits) in the RPN calculator.
//  It accepts PUSH/OPER/DROP/CLEAR commands and keeps a LIFO operand stack.
//  It drives the ALU A/B/Sel/Cin from the two top entries, captures ALU S/Flags, and writes the result back (pop 2, push 1).

---
 rtl/rpn_stack_ctrl_if.sv | 24 ++
 rtl/rpn_stack_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rpn_stack_ctrl_if.sv
// Command channel of the RPN operand-stack controller: request handshake plus
// the one-cycle completion/reject response.
interface rpn_stack_ctrl_if #(
    parameter int W = 8
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_type;
    logic [W-1:0] cmd_data;
    logic [2:0]   cmd_sel;
    logic         cmd_cin;
    logic         done;
    logic         err_stack;

    modport master (
        output cmd_valid, cmd_type, cmd_data, cmd_sel, cmd_cin,
        input  cmd_ready, done, err_stack
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_data, cmd_sel, cmd_cin,
        output cmd_ready, done, err_stack
    );
endinterface

// File: rtl/rpn_stack_ctrl.sv
// LIFO operand stack feeding a combinational 8-bit ALU: PUSH/OPER/DROP/CLEAR,
// with OPER results written back as pop-2/push-1 (or TOS replace for NOT).
module rpn_stack_ctrl #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    rpn_stack_ctrl_if.slave cmd,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [2:0]    alu_sel,
    output logic          alu_cin,
    input  logic [W-1:0]  alu_s,
    input  logic [4:0]    alu_flags,
    output logic [W-1:0]  top_data,
    output logic [DW-1:0] depth,
    output logic          empty,
    output logic          full,
    output logic [4:0]    flags_q
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] CMD_PUSH  = 2'b00;
    localparam logic [1:0] CMD_OPER  = 2'b01;
    localparam logic [1:0] CMD_DROP  = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;
    localparam logic [2:0] SEL_DIV   = 3'b011;
    localparam logic [2:0] SEL_NOT   = 3'b111;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;

    state_t        state_reg, state_next;
    logic [DW-1:0] depth_reg, depth_next;
    logic [W-1:0]  alu_a_reg, alu_a_next;
    logic [W-1:0]  alu_b_reg, alu_b_next;
    logic [2:0]    alu_sel_reg, alu_sel_next;
    logic          alu_cin_reg, alu_cin_next;
    logic [W-1:0]  result_reg, result_next;
    logic [4:0]    flags_reg, flags_next;
    logic          done_reg, done_next;
    logic          err_reg, err_next;

    logic [W-1:0]  stack_mem [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [W-1:0]  mem_wdata;

    logic [DW-1:0] tos_ptr, nos_ptr;
    logic [W-1:0]  tos, nos;
    logic          is_empty, is_full, accept, need_one;

    assign tos_ptr  = depth_reg - DW'(1);
    assign nos_ptr  = depth_reg - DW'(2);
    assign is_empty = (depth_reg == '0);
    assign is_full  = (depth_reg == DW'(DEPTH));
    // Guarded reads: the array is never reset, so empty slots must not leak out.
    assign tos      = is_empty ? '0 : stack_mem[tos_ptr[AW-1:0]];
    assign nos      = (depth_reg >= DW'(2)) ? stack_mem[nos_ptr[AW-1:0]] : '0;
    assign accept   = cmd.cmd_valid && (state_reg == IDLE);
    assign need_one = (cmd.cmd_sel == SEL_NOT);

    always_comb begin
        state_next   = state_reg;
        depth_next   = depth_reg;
        alu_a_next   = alu_a_reg;
        alu_b_next   = alu_b_reg;
        alu_sel_next = alu_sel_reg;
        alu_cin_next = alu_cin_reg;
        result_next  = result_reg;
        flags_next   = flags_reg;
        done_next    = 1'b0;
        err_next     = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = tos_ptr[AW-1:0];
        mem_wdata    = result_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    case (cmd.cmd_type)
                        CMD_PUSH: begin
                            done_next = 1'b1;
                            if (is_full) begin
                                err_next = 1'b1;
                            end else begin
                                mem_we     = 1'b1;
                                mem_waddr  = depth_reg[AW-1:0];
                                mem_wdata  = cmd.cmd_data;
                                depth_next = depth_reg + DW'(1);
                            end
                        end
                        CMD_OPER: begin
                            if (depth_reg < (need_one ? DW'(1) : DW'(2))) begin
                                done_next = 1'b1;
                                err_next  = 1'b1;
                            end else begin
                                state_next   = FETCH;
                                alu_a_next   = need_one ? tos : nos;
                                alu_b_next   = need_one ? '0 : tos;
                                alu_sel_next = cmd.cmd_sel;
                                alu_cin_next = cmd.cmd_cin;
                            end
                        end
                        CMD_DROP: begin
                            done_next = 1'b1;
                            if (is_empty) err_next = 1'b1;
                            else          depth_next = depth_reg - DW'(1);
                        end
                        default: begin
                            done_next  = 1'b1;
                            depth_next = '0;
                            flags_next = '0;
                        end
                    endcase
                end
            end
            FETCH: state_next = EXEC;
            EXEC: begin
                result_next = alu_s;
                flags_next  = alu_flags;
                state_next  = WB;
            end
            default: begin
                state_next = IDLE;
                done_next  = 1'b1;
                // A divide by zero leaves the operands in place; flags_q carries erro.
                if (!(alu_sel_reg == SEL_DIV && flags_reg[3])) begin
                    mem_we = 1'b1;
                    if (alu_sel_reg == SEL_NOT) begin
                        mem_waddr = tos_ptr[AW-1:0];
                    end else begin
                        mem_waddr  = nos_ptr[AW-1:0];
                        depth_next = depth_reg - DW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            depth_reg   <= '0;
            alu_a_reg   <= '0;
            alu_b_reg   <= '0;
            alu_sel_reg <= '0;
            alu_cin_reg <= 1'b0;
            result_reg  <= '0;
            flags_reg   <= '0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            depth_reg   <= depth_next;
            alu_a_reg   <= alu_a_next;
            alu_b_reg   <= alu_b_next;
            alu_sel_reg <= alu_sel_next;
            alu_cin_reg <= alu_cin_next;
            result_reg  <= result_next;
            flags_reg   <= flags_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) stack_mem[mem_waddr] <= mem_wdata;
    end

    assign cmd.cmd_ready = (state_reg == IDLE);
    assign cmd.done      = done_reg;
    assign cmd.err_stack = err_reg;
    assign alu_a         = alu_a_reg;
    assign alu_b         = alu_b_reg;
    assign alu_sel       = alu_sel_reg;
    assign alu_cin       = alu_cin_reg;
    assign top_data      = tos;
    assign depth         = depth_reg;
    assign empty         = is_empty;
    assign full          = is_full;
    assign flags_q       = flags_reg;
endmodule
